// File: rtl/control.sv
// ----------------------------------------------------------------------------
// control : main opcode decoder for the single-issue RV32 datapath.
//           Combinational decode feeding one registered output stage.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module control (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] opcode,
   output logic       ALUsrc,
   output logic       mem2reg,
   output logic       reg_write,
   output logic       mem_read,
   output logic       mem_write,
   output logic       branch,
   output logic [1:0] ALU_op,
   output logic       illegal
);

   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_IALU   = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   // Packed as {ALUsrc, mem2reg, reg_write, mem_read, mem_write, branch, ALU_op, illegal}
   logic [8:0] ctrl_next;
   logic [8:0] ctrl_reg;

   // Unknown opcode bits miss every case item and fall through to illegal.
   always_comb begin
      ctrl_next = 9'b0_0_0_0_0_0_00_1;
      case (opcode)
         OP_RTYPE:  ctrl_next = 9'b0_0_1_0_0_0_10_0;
         OP_IALU:   ctrl_next = 9'b1_0_1_0_0_0_11_0;
         OP_LOAD:   ctrl_next = 9'b1_1_1_1_0_0_00_0;
         OP_STORE:  ctrl_next = 9'b1_0_0_0_1_0_00_0;
         OP_BRANCH: ctrl_next = 9'b0_0_0_0_0_1_01_0;
         OP_JALR:   ctrl_next = 9'b0_0_0_0_0_1_01_0;
         default:   ctrl_next = 9'b0_0_0_0_0_0_00_1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ctrl_reg <= 9'b0;
      end else begin
         ctrl_reg <= ctrl_next;
      end
   end

   assign ALUsrc    = ctrl_reg[8];
   assign mem2reg   = ctrl_reg[7];
   assign reg_write = ctrl_reg[6];
   assign mem_read  = ctrl_reg[5];
   assign mem_write = ctrl_reg[4];
   assign branch    = ctrl_reg[3];
   assign ALU_op    = ctrl_reg[2:1];
   assign illegal   = ctrl_reg[0];

endmodule

`default_nettype wire

// File: tb/tb_control.sv
// ----------------------------------------------------------------------------
// tb_control : directed and exhaustive scoreboard bench for the control decoder.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_control;

   logic       clk;
   logic       rst;
   logic [6:0] opcode;
   logic       ALUsrc;
   logic       mem2reg;
   logic       reg_write;
   logic       mem_read;
   logic       mem_write;
   logic       branch;
   logic [1:0] ALU_op;
   logic       illegal;

   int tests_run;
   int tests_failed;

   logic [8:0] sb [$];

   control dut (
      .clk       (clk),
      .rst       (rst),
      .opcode    (opcode),
      .ALUsrc    (ALUsrc),
      .mem2reg   (mem2reg),
      .reg_write (reg_write),
      .mem_read  (mem_read),
      .mem_write (mem_write),
      .branch    (branch),
      .ALU_op    (ALU_op),
      .illegal   (illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   // Reference decode written field by field from the opcode table.
   function automatic logic [8:0] ref_decode(input logic [6:0] op);
      logic       is_r, is_i, is_ld, is_st, is_br, legal;
      logic [1:0] aop;
      is_r  = (op == 7'b0110011);
      is_i  = (op == 7'b0010011);
      is_ld = (op == 7'b0000011);
      is_st = (op == 7'b0100011);
      is_br = (op == 7'b1100011) || (op == 7'b1100111);
      legal = is_r | is_i | is_ld | is_st | is_br;
      aop   = is_r ? 2'b10 : is_i ? 2'b11 : is_br ? 2'b01 : 2'b00;
      return {is_i | is_ld | is_st, is_ld, is_r | is_i | is_ld,
              is_ld, is_st, is_br, aop, ~legal};
   endfunction

   function automatic logic [8:0] observed();
      return {ALUsrc, mem2reg, reg_write, mem_read, mem_write, branch, ALU_op, illegal};
   endfunction

   task automatic check_outputs(input string tag);
      logic [8:0] exp_v;
      logic [8:0] obs_v;
      obs_v = observed();
      tests_run++;
      if (sb.size() == 0) begin
         tests_failed++;
         $display("FAIL %s observed=%b expected=<scoreboard empty>", tag, obs_v);
      end else begin
         exp_v = sb.pop_front();
         assert (obs_v === exp_v) else begin
            tests_failed++;
            $error("FAIL %s observed=%b expected=%b", tag, obs_v, exp_v);
         end
      end
      tests_run++;
      assert ((mem_read & mem_write) === 1'b0) else begin
         tests_failed++;
         $error("FAIL %s_rd_wr_excl observed=%b%b expected=not both", tag, mem_read, mem_write);
      end
      tests_run++;
      assert ((reg_write & (mem_write | branch)) === 1'b0) else begin
         tests_failed++;
         $error("FAIL %s_wr_excl observed=rw%b mw%b br%b expected=no overlap",
                tag, reg_write, mem_write, branch);
      end
   endtask

   // Drive on the falling edge, expect the result just after the next rising edge.
   task automatic step(input logic [6:0] op, input logic r, input string tag);
      @(negedge clk);
      opcode = op;
      rst    = r;
      sb.push_back(r ? 9'b0 : ref_decode(op));
      @(posedge clk);
      #1;
      check_outputs(tag);
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      rst          = 1'b1;
      opcode       = 7'b0110011;

      step(7'b0110011, 1'b1, "reset0");
      step(7'b0110011, 1'b1, "reset1");
      step(7'b0110011, 1'b0, "reset_release_rtype");

      step(7'b0110011, 1'b0, "sweep_rtype");
      step(7'b0000011, 1'b0, "sweep_load");
      step(7'b0100011, 1'b0, "sweep_store");
      step(7'b1100111, 1'b0, "sweep_jalr");
      step(7'b1100011, 1'b0, "sweep_branch");
      step(7'b0010011, 1'b0, "sweep_ialu");

      step(7'b0000000, 1'b0, "illegal_zero");
      step(7'b1111111, 1'b0, "illegal_ones");
      step(7'b0110111, 1'b0, "illegal_lui");
      step(7'b0100011, 1'b0, "illegal_clear_store");

      step(7'b0100011, 1'b0, "b2b_store0");
      step(7'b0000011, 1'b0, "b2b_load");
      step(7'b0100011, 1'b0, "b2b_store1");

      step(7'b0000011, 1'b1, "midreset_load");
      step(7'b0000011, 1'b0, "midreset_release_load");
      step(7'b1111111, 1'b1, "reset_masks_illegal");

      for (int i = 0; i < 128; i++) begin
         step(i[6:0], 1'b0, "exhaustive");
      end

      tests_run++;
      assert (sb.size() == 0) else begin
         tests_failed++;
         $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

`default_nettype wire
